timestamp_gate: RTL

TIMESTAMP_GATE -- requirements
Module: timestamp_gate

---
 rtl/util_upack2_timestamp_pkg.sv | 37 +++
 rtl/timestamp_counter.sv | 37 +++
 rtl/timestamp_gate.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/util_upack2_timestamp_pkg.sv
// -----------------------------------------------------------------------------
// util_upack2_timestamp
//   Shared definitions for the timestamp gate that sits in front of the
//   sample unpacker: the gate FSM state encoding, the timestamp width, and the
//   two timestamp comparisons the gate makes.
// -----------------------------------------------------------------------------
package util_upack2_timestamp;

    // Width of the sample counter, of the header timestamp and of a DMA word.
    localparam int TS_W = 64;

    // Gate FSM states.
    //   IDLE   : waiting for a packet header
    //   WAIT   : header seen, holding the payload until the counter catches up
    //   STREAM : forwarding payload words to the unpacker
    //   DROP   : discarding the payload of a late packet
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2,
        DROP   = 2'd3
    } ts_state_t;

    // A header is late when its timestamp is already behind the counter.
    // Both operands are unsigned sample indices.
    function automatic logic ts_is_late(input logic [TS_W-1:0] cnt,
                                        input logic [TS_W-1:0] ts);
        return cnt > ts;
    endfunction

    // The payload may start once the counter has reached the timestamp.
    function automatic logic ts_reached(input logic [TS_W-1:0] cnt,
                                        input logic [TS_W-1:0] ts);
        return cnt >= ts;
    endfunction

endpackage

// File: rtl/timestamp_counter.sv
// -----------------------------------------------------------------------------
// timestamp_counter
//   Free-running sample counter. Advances once per DAC sample period and can
//   be loaded with an absolute sample index. A load wins over a strobe in the
//   same cycle; the count wraps from all-ones to zero.
//
// Ports
//   clk        : clock
//   resetn     : synchronous active-low reset, clears the count
//   load       : load the counter from load_value this cycle
//   load_value : value to load
//   strobe     : one sample period elapsed, increment the count
//   count      : current counter value (registered)
// -----------------------------------------------------------------------------
module timestamp_counter
    import util_upack2_timestamp::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic [TS_W-1:0] load_value,
    input  logic            strobe,
    output logic [TS_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (strobe) begin
            // Natural modulo-2^TS_W wrap.
            count <= count + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/timestamp_gate.sv
// -----------------------------------------------------------------------------
// timestamp_gate
//   Holds DMA packets until the sample counter reaches the timestamp carried
//   in each packet's first word, then forwards the remaining words to the
//   unpacker through a one-stage output register. Packets whose timestamp has
//   already passed are either dropped or streamed immediately (DROP_LATE).
//
// Parameters
//   DROP_LATE      : 1 = discard late packets, 0 = stream them immediately
//
// Ports
//   clk            : single clock
//   resetn         : synchronous active-low reset
//   en             : block enable; low aborts any packet and forces IDLE
//   sample_strobe  : one DAC sample period elapsed, advances the counter
//   cnt_load       : load the counter from cnt_load_value
//   cnt_load_value : counter load value
//   s_data/s_valid/s_ready/s_last : DMA input stream, first word = header
//   m_data/m_valid/m_ready        : payload stream to the unpacker
//   counter        : current sample counter value
//   late_pulse     : one-cycle pulse after a late header is accepted
//   waiting        : high while the gate is in WAIT
// -----------------------------------------------------------------------------
module timestamp_gate
    import util_upack2_timestamp::*;
#(
    parameter int DROP_LATE = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic            sample_strobe,
    input  logic            cnt_load,
    input  logic [TS_W-1:0] cnt_load_value,
    input  logic [TS_W-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_last,
    output logic [TS_W-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [TS_W-1:0] counter,
    output logic            late_pulse,
    output logic            waiting
);

    ts_state_t       state;
    logic [TS_W-1:0] ts_reg;

    // One-stage output register towards the unpacker.
    logic [TS_W-1:0] data_p1;
    logic            vld_p1;

    logic            late_p1;
    logic            waiting_p1;

    logic            out_free;
    logic            s_fire;
    logic            hdr_late;

    // -------------------------------------------------------------------------
    // Sample counter
    // -------------------------------------------------------------------------
    timestamp_counter u_counter (
        .clk        (clk),
        .resetn     (resetn),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .strobe     (sample_strobe),
        .count      (counter)
    );

    // -------------------------------------------------------------------------
    // Input handshake
    // -------------------------------------------------------------------------
    // The output register can take a new word when it is empty or being
    // drained this cycle. IDLE uses the same condition so that a new header is
    // not taken while the previous packet's last word is still stalled.
    assign out_free = ~vld_p1 | m_ready;

    always_comb begin
        s_ready = 1'b0;
        if (resetn && en) begin
            unique case (state)
                IDLE:    s_ready = out_free;
                WAIT:    s_ready = 1'b0;
                STREAM:  s_ready = out_free;
                DROP:    s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign s_fire = s_valid & s_ready;

    // Lateness uses the counter value present in the header cycle, before any
    // strobe in that same cycle takes effect.
    assign hdr_late = ts_is_late(counter, s_data);

    // -------------------------------------------------------------------------
    // Gate FSM and output register (stage p1)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            ts_reg     <= '0;
            data_p1    <= '0;
            vld_p1     <= 1'b0;
            late_p1    <= 1'b0;
            waiting_p1 <= 1'b0;
        end else begin
            late_p1 <= 1'b0;

            // Downstream took the current word.
            if (vld_p1 && m_ready) begin
                vld_p1 <= 1'b0;
            end

            if (!en) begin
                // Abort whatever was in flight, including a stalled output word.
                state      <= IDLE;
                vld_p1     <= 1'b0;
                waiting_p1 <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (s_fire) begin
                            ts_reg  <= s_data;
                            late_p1 <= hdr_late;
                            if (s_last) begin
                                // Header-only packet: nothing to forward.
                                state <= IDLE;
                            end else if (!hdr_late) begin
                                state      <= WAIT;
                                waiting_p1 <= 1'b1;
                            end else if (DROP_LATE != 0) begin
                                state <= DROP;
                            end else begin
                                state <= STREAM;
                            end
                        end
                    end

                    WAIT: begin
                        if (ts_reached(counter, ts_reg)) begin
                            state      <= STREAM;
                            waiting_p1 <= 1'b0;
                        end
                    end

                    STREAM: begin
                        if (s_fire) begin
                            data_p1 <= s_data;
                            vld_p1  <= 1'b1;
                            // The last word still drains through the
                            // output register after we return to IDLE.
                            if (s_last) begin
                                state <= IDLE;
                            end
                        end
                    end

                    DROP: begin
                        if (s_fire && s_last) begin
                            state <= IDLE;
                        end
                    end

                    default: begin
                        state      <= IDLE;
                        waiting_p1 <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_data     = data_p1;
    assign m_valid    = vld_p1;
    assign late_pulse = late_p1;
    assign waiting    = waiting_p1;

endmodule
